// File: rtl/udp_payload_reducer.sv
// udp_payload_reducer
//   Reduces the payload lanes of beat-streamed UDP packets with SUM, MAX or
//   MIN (selected by a 16-bit opcode taken from a fixed header field) and
//   queues one result word per packet in a show-ahead result FIFO.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   In_data    packet beat (DATA_W bits)
//   In_valid   beat valid
//   In_last    final beat of the packet
//   In_ready   beat accepted when In_valid && In_ready
//   Out_data   result word: [ACC_W-1:0] result, [ACC_W+15:ACC_W] opcode,
//              [ACC_W+31:ACC_W+16] beat count, [ACC_W+32] err, rest 0
//   Out_valid  result available
//   Out_ready  result consumed when Out_valid && Out_ready
module udp_payload_reducer #(
  parameter int DATA_W    = 256,
  parameter int LANE_W    = 32,
  parameter int ACC_W     = 32,
  parameter int HDR_BEATS = 2,
  parameter int OPC_BEAT  = 1,
  parameter int OPC_LSB   = 160,
  parameter int RES_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] In_data,
  input  logic              In_valid,
  input  logic              In_last,
  output logic              In_ready,
  output logic [DATA_W-1:0] Out_data,
  output logic              Out_valid,
  input  logic              Out_ready
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int PW    = $clog2(RES_DEPTH);
  localparam int CW    = PW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;

  localparam logic [15:0] HDR_LAST = 16'(HDR_BEATS - 1);
  localparam logic [15:0] OPC_IDX  = 16'(OPC_BEAT);
  localparam logic [15:0] OPC_SUM  = 16'd1;
  localparam logic [15:0] OPC_MAX  = 16'd2;
  localparam logic [15:0] OPC_MIN  = 16'd3;

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(RES_DEPTH);

  // ---------------- stage 0: framing, beat counter, opcode latch ----------
  logic              ready_en_r;
  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [15:0]       cnt_r;
  logic [15:0]       cnt_inc_s;
  logic [15:0]       opc_r;
  logic [15:0]       opc_nxt_s;
  logic              accept_s;
  logic              is_hdr_s;

  // lane tree of the incoming beat
  logic [ACC_W-1:0]  lane_sum_s;
  logic [LANE_W-1:0] lane_max_s;
  logic [LANE_W-1:0] lane_min_s;

  // ---------------- stage 1 registers -------------------------------------
  logic              s1_valid_r;
  logic              s1_last_r;
  logic              s1_pay_r;
  logic              s1_short_r;
  logic [15:0]       s1_opc_r;
  logic [15:0]       s1_cnt_r;
  logic [ACC_W-1:0]  s1_sum_r;
  logic [LANE_W-1:0] s1_max_r;
  logic [LANE_W-1:0] s1_min_r;

  // ---------------- stage 2: accumulators and result ----------------------
  logic [ACC_W-1:0]  acc_sum_r;
  logic [ACC_W-1:0]  acc_max_r;
  logic [ACC_W-1:0]  acc_min_r;
  logic [ACC_W-1:0]  acc_sum_nxt_s;
  logic [ACC_W-1:0]  acc_max_nxt_s;
  logic [ACC_W-1:0]  acc_min_nxt_s;
  logic [ACC_W-1:0]  res_val_s;
  logic              err_s;
  logic [DATA_W-1:0] res_word_s;
  logic [DATA_W-1:0] res_r;
  logic              res_vld_r;

  // ---------------- result FIFO -------------------------------------------
  logic [DATA_W-1:0] mem_r [RES_DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     fifo_cnt_r;
  logic [CW-1:0]     pend_r;
  logic [CW:0]       occ_s;
  logic              push_s;
  logic              pop_s;

  // Beat acceptance, header classification and next-state for framing.
  always_comb begin
    accept_s  = In_valid && In_ready;
    is_hdr_s  = (state_r != ST_PAY);
    cnt_inc_s = (cnt_r == 16'hFFFF) ? cnt_r : (cnt_r + 16'd1);
    // cnt_r is the 0-based index of the current beat while in the header
    if (is_hdr_s && (cnt_r == OPC_IDX)) begin
      opc_nxt_s = In_data[OPC_LSB +: 16];
    end else begin
      opc_nxt_s = opc_r;
    end
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_HDR: begin
        if (In_last) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == HDR_LAST) begin
          state_nxt_s = ST_PAY;
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_PAY: begin
        if (In_last) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PAY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Lane reduction of the incoming beat (sum modulo 2^ACC_W, unsigned max/min).
  always_comb begin
    lane_sum_s = '0;
    lane_max_s = '0;
    lane_min_s = '1;
    for (int i = 0; i < LANES; i++) begin
      lane_sum_s = lane_sum_s + ACC_W'(In_data[i*LANE_W +: LANE_W]);
      if (In_data[i*LANE_W +: LANE_W] > lane_max_s) begin
        lane_max_s = In_data[i*LANE_W +: LANE_W];
      end else begin
        lane_max_s = lane_max_s;
      end
      if (In_data[i*LANE_W +: LANE_W] < lane_min_s) begin
        lane_min_s = In_data[i*LANE_W +: LANE_W];
      end else begin
        lane_min_s = lane_min_s;
      end
    end
  end

  // Framing state; counter and opcode clear at packet end for the next packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en_r <= 1'b0;
      state_r    <= ST_IDLE;
      cnt_r      <= 16'd0;
      opc_r      <= 16'd0;
    end else begin
      ready_en_r <= 1'b1;
      if (accept_s) begin
        state_r <= state_nxt_s;
        if (In_last) begin
          cnt_r <= 16'd0;
          opc_r <= 16'd0;
        end else begin
          cnt_r <= cnt_inc_s;
          opc_r <= opc_nxt_s;
        end
      end
    end
  end

  // Stage 1: register the accepted beat's lane tree and per-packet context.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_pay_r   <= 1'b0;
      s1_short_r <= 1'b0;
      s1_opc_r   <= 16'd0;
      s1_cnt_r   <= 16'd0;
      s1_sum_r   <= '0;
      s1_max_r   <= '0;
      s1_min_r   <= '0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_last_r  <= In_last;
        s1_pay_r   <= !is_hdr_s;
        s1_short_r <= is_hdr_s && In_last;
        s1_opc_r   <= opc_nxt_s;
        s1_cnt_r   <= cnt_inc_s;
        s1_sum_r   <= lane_sum_s;
        s1_max_r   <= lane_max_s;
        s1_min_r   <= lane_min_s;
      end
    end
  end

  // Stage 2: fold the beat into all three accumulators; the opcode only
  // selects among them at commit, so re-initialisation needs no opcode.
  always_comb begin
    acc_sum_nxt_s = acc_sum_r;
    acc_max_nxt_s = acc_max_r;
    acc_min_nxt_s = acc_min_r;
    if (s1_valid_r && s1_pay_r) begin
      acc_sum_nxt_s = acc_sum_r + s1_sum_r;
      acc_max_nxt_s = (ACC_W'(s1_max_r) > acc_max_r) ? ACC_W'(s1_max_r) : acc_max_r;
      acc_min_nxt_s = (ACC_W'(s1_min_r) < acc_min_r) ? ACC_W'(s1_min_r) : acc_min_r;
    end else begin
      acc_sum_nxt_s = acc_sum_r;
    end
    case (s1_opc_r)
      OPC_SUM: begin res_val_s = acc_sum_nxt_s; err_s = s1_short_r; end
      OPC_MAX: begin res_val_s = acc_max_nxt_s; err_s = s1_short_r; end
      OPC_MIN: begin res_val_s = acc_min_nxt_s; err_s = s1_short_r; end
      default: begin res_val_s = '0;            err_s = 1'b1;       end
    endcase
    if (err_s) begin
      res_val_s = '0;
    end else begin
      res_val_s = res_val_s;
    end
    res_word_s = '0;
    res_word_s[ACC_W-1:0]     = res_val_s;
    res_word_s[ACC_W +: 16]   = s1_opc_r;
    res_word_s[ACC_W+16 +: 16] = s1_cnt_r;
    res_word_s[ACC_W+32]      = err_s;
  end

  // Stage 2 registers: accumulators, and the committed result word which is
  // pushed into the FIFO one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_sum_r <= '0;
      acc_max_r <= '0;
      acc_min_r <= '1;
      res_r     <= '0;
      res_vld_r <= 1'b0;
    end else begin
      res_vld_r <= s1_valid_r && s1_last_r;
      if (s1_valid_r && s1_last_r) begin
        res_r     <= res_word_s;
        acc_sum_r <= '0;
        acc_max_r <= '0;
        acc_min_r <= '1;
      end else begin
        acc_sum_r <= acc_sum_nxt_s;
        acc_max_r <= acc_max_nxt_s;
        acc_min_r <= acc_min_nxt_s;
      end
    end
  end

  // FIFO control and admission; In_ready reserves a slot for every packet
  // whose last beat is in flight, so a push never finds the FIFO full.
  always_comb begin
    push_s   = res_vld_r;
    pop_s    = Out_valid && Out_ready;
    occ_s    = {1'b0, fifo_cnt_r} + {1'b0, pend_r};
    In_ready = ready_en_r && (occ_s < DEPTH_C);
    Out_valid = (fifo_cnt_r != '0);
    if (Out_valid) begin
      Out_data = mem_r[rd_ptr_r];
    end else begin
      Out_data = '0;
    end
  end

  // FIFO storage (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= res_r;
    end
  end

  // FIFO pointers, occupancy and pending-commit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
      pend_r     <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
      case ({accept_s && In_last, push_s})
        2'b10:   pend_r <= pend_r + CNT_ONE;
        2'b01:   pend_r <= pend_r - CNT_ONE;
        default: pend_r <= pend_r;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_payload_reducer.sv
// Directed testbench for udp_payload_reducer (default parameters).
module tb_udp_payload_reducer;

  logic         clk;
  logic         reset;
  logic [255:0] In_data;
  logic         In_valid;
  logic         In_last;
  logic         In_ready;
  logic [255:0] Out_data;
  logic         Out_valid;
  logic         Out_ready;

  int tests_run;
  int tests_failed;

  udp_payload_reducer dut (
    .clk       (clk),
    .reset     (reset),
    .In_data   (In_data),
    .In_valid  (In_valid),
    .In_last   (In_last),
    .In_ready  (In_ready),
    .Out_data  (Out_data),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] fill(input logic [31:0] v);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = v;
    return d;
  endfunction

  // lanes 5..12
  function automatic logic [255:0] seq5();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'(5 + i);
    return d;
  endfunction

  // header beat with junk lanes and the opcode field set
  function automatic logic [255:0] hdr(input logic [15:0] opc);
    logic [255:0] d;
    d = fill(32'h0000_0099);
    d[160 +: 16] = opc;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded); leaves In_valid high.
  task automatic send_beat(input logic [255:0] d, input logic l);
    int n;
    n = 0;
    In_data  = d;
    In_valid = 1'b1;
    In_last  = l;
    while (!In_ready && n < 200) begin
      tick();
      n++;
    end
    if (!In_ready) check_eq("in_ready_timeout", 64'd0, 64'd1);
    tick();
  endtask

  task automatic idle();
    In_valid = 1'b0;
    In_last  = 1'b0;
    In_data  = '0;
  endtask

  // Wait (bounded) for a result, check all fields, then pop it.
  task automatic expect_result(input string tag, input logic [31:0] res, input logic [15:0] opc,
                               input logic [15:0] cnt, input logic err);
    int n;
    n = 0;
    while (!Out_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, 64'(Out_valid), 64'd1);
    check_eq({tag, "_res"},   64'(Out_data[31:0]),  64'(res));
    check_eq({tag, "_opc"},   64'(Out_data[47:32]), 64'(opc));
    check_eq({tag, "_cnt"},   64'(Out_data[63:48]), 64'(cnt));
    check_eq({tag, "_err"},   64'(Out_data[64]),    64'(err));
    check_eq({tag, "_pad"},   64'(|Out_data[255:65]), 64'd0);
    Out_ready = 1'b1;
    tick();
    Out_ready = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset     = 1'b1;
    Out_ready = 1'b0;
    idle();
    #12;
    check_eq("rst_in_ready",  64'(In_ready),  64'd0);
    check_eq("rst_out_valid", 64'(Out_valid), 64'd0);
    check_eq("rst_out_data",  64'(|Out_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_eq("post_rst_in_ready", 64'(In_ready), 64'd1);

    // SUM, 4 beats, lanes = 1 -> 16; latency 2 cycles after last accept
    send_beat(hdr(16'h00AA), 1'b0);
    send_beat(hdr(16'd1), 1'b0);
    send_beat(fill(32'd1), 1'b0);
    send_beat(fill(32'd1), 1'b1);
    idle();
    check_eq("sum_lat0", 64'(Out_valid), 64'd0);
    tick();
    check_eq("sum_lat1", 64'(Out_valid), 64'd0);
    tick();
    check_eq("sum_lat2", 64'(Out_valid), 64'd1);
    expect_result("sum", 32'd16, 16'd1, 16'd4, 1'b0);

    // MAX then MIN back to back
    send_beat(hdr(16'h00AA), 1'b0);
    send_beat(hdr(16'd2), 1'b0);
    send_beat(seq5(), 1'b0);
    send_beat(seq5(), 1'b1);
    send_beat(hdr(16'h00AA), 1'b0);
    send_beat(hdr(16'd3), 1'b0);
    send_beat(seq5(), 1'b1);
    idle();
    expect_result("max", 32'd12, 16'd2, 16'd4, 1'b0);
    expect_result("min", 32'd5,  16'd3, 16'd3, 1'b0);

    // SUM wrap-around
    send_beat(hdr(16'h00AA), 1'b0);
    send_beat(hdr(16'd1), 1'b0);
    send_beat(fill(32'hFFFF_FFFF), 1'b1);
    idle();
    expect_result("wrap", 32'hFFFF_FFF8, 16'd1, 16'd3, 1'b0);

    // Backpressure: four packets fill FIFO + pending
    for (int k = 1; k <= 4; k++) begin
      send_beat(hdr(16'h00AA), 1'b0);
      send_beat(hdr(16'd1), 1'b0);
      send_beat(fill(32'(k)), 1'b1);
    end
    check_eq("bp_ready_drop", 64'(In_ready), 64'd0);
    // beat presented while not ready must be ignored
    In_data  = fill(32'h0000_00AB);
    In_valid = 1'b1;
    In_last  = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    idle();
    check_eq("bp_ready_held", 64'(In_ready),  64'd0);
    check_eq("bp_out_valid",  64'(Out_valid), 64'd1);
    expect_result("bp1", 32'd8, 16'd1, 16'd3, 1'b0);
    check_eq("bp_ready_recover", 64'(In_ready), 64'd1);
    send_beat(hdr(16'h00AA), 1'b0);
    send_beat(hdr(16'd1), 1'b0);
    send_beat(fill(32'd5), 1'b1);
    idle();
    expect_result("bp2", 32'd16, 16'd1, 16'd3, 1'b0);
    expect_result("bp3", 32'd24, 16'd1, 16'd3, 1'b0);
    expect_result("bp4", 32'd32, 16'd1, 16'd3, 1'b0);
    expect_result("bp5", 32'd40, 16'd1, 16'd3, 1'b0);
    tick();
    check_eq("bp_drained", 64'(Out_valid), 64'd0);

    // Error cases: bad opcode, 1-beat packet
    send_beat(hdr(16'h00AA), 1'b0);
    send_beat(hdr(16'd7), 1'b0);
    send_beat(fill(32'd3), 1'b1);
    send_beat(fill(32'd5), 1'b1);
    idle();
    expect_result("bad_opc", 32'd0, 16'd7, 16'd3, 1'b1);
    expect_result("short",   32'd0, 16'd0, 16'd1, 1'b1);

    // Reset mid-packet with a stored result
    send_beat(hdr(16'h00AA), 1'b0);
    send_beat(hdr(16'd1), 1'b0);
    send_beat(fill(32'd1), 1'b1);
    send_beat(hdr(16'h00AA), 1'b0);
    send_beat(hdr(16'd2), 1'b0);
    send_beat(fill(32'd100), 1'b0);
    idle();
    tick();
    tick();
    check_eq("pre_rst_valid", 64'(Out_valid), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", 64'(Out_valid), 64'd0);
    check_eq("mid_rst_data",  64'(|Out_data), 64'd0);
    check_eq("mid_rst_ready", 64'(In_ready),  64'd0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_eq("rel_ready", 64'(In_ready),  64'd1);
    check_eq("rel_valid", 64'(Out_valid), 64'd0);
    send_beat(hdr(16'h00AA), 1'b0);
    send_beat(hdr(16'd1), 1'b0);
    send_beat(fill(32'd2), 1'b0);
    send_beat(fill(32'd2), 1'b1);
    idle();
    expect_result("after_rst", 32'd32, 16'd1, 16'd4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
